// File: rtl/sw_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg: shared constants and helpers for the switch conditioner.
//   N_GROUPS   number of 4-bit switch groups (one per PWM slot)
//   GROUP_W    switches per group
//   DUTY_W     width of a duty word (popcount of one group, 0..4)
//   popcount4  number of set bits in one group
// -----------------------------------------------------------------------------
package sw_pkg;

    localparam int N_GROUPS = 4;
    localparam int GROUP_W  = 4;
    localparam int DUTY_W   = 3;

    function automatic logic [DUTY_W-1:0] popcount4(input logic [3:0] v);
        return DUTY_W'(v[0]) + DUTY_W'(v[1]) + DUTY_W'(v[2]) + DUTY_W'(v[3]);
    endfunction

endpackage

// File: rtl/sw_conditioner_if.sv
// -----------------------------------------------------------------------------
// sw_conditioner_if: signal bundle between the switch conditioner and its user.
//   sw_raw      raw, asynchronous board switches; [4g+3:4g] is group g
//   frame_tick  1-cycle frame-start pulse from the PWM stage
//   sw0..sw3    latched debounced switch groups
//   duty0..3    popcount of the matching swN
//   upd_pulse   1-cycle flag: the last latch changed some swN
// master modport drives the inputs (bench / PWM side), slave is the conditioner.
// -----------------------------------------------------------------------------
interface sw_conditioner_if import sw_pkg::*; ();

    logic [N_GROUPS*GROUP_W-1:0] sw_raw;
    logic                        frame_tick;
    logic [GROUP_W-1:0]          sw0, sw1, sw2, sw3;
    logic [DUTY_W-1:0]           duty0, duty1, duty2, duty3;
    logic                        upd_pulse;

    modport master (
        output sw_raw, frame_tick,
        input  sw0, sw1, sw2, sw3, duty0, duty1, duty2, duty3, upd_pulse
    );

    modport slave (
        input  sw_raw, frame_tick,
        output sw0, sw1, sw2, sw3, duty0, duty1, duty2, duty3, upd_pulse
    );

endinterface

// File: rtl/sw_conditioner_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit: 2-FF synchroniser followed by a consecutive-disagreement
// counter for one switch bit.
//   clk, rst   clock, synchronous active-high reset
//   raw_i      asynchronous raw switch bit
//   stable_o   debounced level; changes only after DEBOUNCE_CYCLES consecutive
//              edges on which the synchronised input disagreed with it
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter is cleared on acceptance, so it never exceeds CNT_LAST.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sw_conditioner.sv
// -----------------------------------------------------------------------------
// sw_conditioner: debounces 16 raw switches and presents them to the PWM stage
// as four 4-bit groups plus popcount duty words, updated only on frame_tick.
//   clk, rst   25 MHz PWM-domain clock, synchronous active-high reset
//   bus        sw_conditioner_if.slave (sw_raw, frame_tick in; sw0..3,
//              duty0..3, upd_pulse out)
// -----------------------------------------------------------------------------
module sw_conditioner import sw_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst,
    sw_conditioner_if.slave  bus
);

    logic [N_GROUPS*GROUP_W-1:0]            stable_flat;
    logic [N_GROUPS-1:0][GROUP_W-1:0]       stable_w;
    logic [N_GROUPS-1:0][GROUP_W-1:0]       sw_q, sw_d;
    logic [N_GROUPS-1:0][DUTY_W-1:0]        duty_q, duty_d;
    logic                                   upd_q, upd_d;

    for (genvar i = 0; i < N_GROUPS*GROUP_W; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (bus.sw_raw[i]),
            .stable_o(stable_flat[i])
        );
    end

    assign stable_w = stable_flat;

    // Frame latch: samples the registered stable bits, so a bit accepted on
    // the tick edge itself is only picked up by the following tick. swN and
    // dutyN are loaded together and can never disagree.
    always_comb begin
        sw_d   = sw_q;
        duty_d = duty_q;
        upd_d  = 1'b0;
        if (bus.frame_tick) begin
            sw_d  = stable_w;
            upd_d = (stable_w != sw_q);
            for (int g = 0; g < N_GROUPS; g++) begin
                duty_d[g] = popcount4(stable_w[g]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q   <= '0;
            duty_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            sw_q   <= sw_d;
            duty_q <= duty_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.sw0       = sw_q[0];
    assign bus.sw1       = sw_q[1];
    assign bus.sw2       = sw_q[2];
    assign bus.sw3       = sw_q[3];
    assign bus.duty0     = duty_q[0];
    assign bus.duty1     = duty_q[1];
    assign bus.duty2     = duty_q[2];
    assign bus.duty3     = duty_q[3];
    assign bus.upd_pulse = upd_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sw_conditioner: directed bench for sw_conditioner with DEBOUNCE_CYCLES=8.
// Each step pushes the output state expected from a given edge onward into a
// scoreboard queue; a negedge checker pops entries as their edge arrives and
// compares the full output state every cycle.
// -----------------------------------------------------------------------------
module tb_sw_conditioner;

    localparam int DB = 8;

    typedef struct {
        int unsigned cyc;
        logic [15:0] sw;
        logic [11:0] duty;   // {duty3, duty2, duty1, duty0}
        logic        upd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    exp_t exp_cur = '{cyc: 0, sw: 16'h0000, duty: 12'h000, upd: 1'b0};

    sw_conditioner_if bus_if ();

    sw_conditioner #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int unsigned c, input logic [15:0] sw,
                                 input logic [2:0] d3, input logic [2:0] d2,
                                 input logic [2:0] d1, input logic [2:0] d0,
                                 input logic upd);
        exp_t e;
        e.cyc  = c;
        e.sw   = sw;
        e.duty = {d3, d2, d1, d0};
        e.upd  = upd;
        sb.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Checker: cyc equals the index of the most recent posedge.
    always @(negedge clk) begin
        logic [15:0] obs_sw;
        logic [11:0] obs_duty;
        while (sb.size() != 0 && sb[0].cyc <= cyc) exp_cur = sb.pop_front();
        obs_sw   = {bus_if.sw3, bus_if.sw2, bus_if.sw1, bus_if.sw0};
        obs_duty = {bus_if.duty3, bus_if.duty2, bus_if.duty1, bus_if.duty0};
        n_checks++;
        assert (obs_sw === exp_cur.sw) else begin
            n_fail++;
            $error("FAIL sw edge=%0d observed=%h expected=%h", cyc, obs_sw, exp_cur.sw);
        end
        n_checks++;
        assert (obs_duty === exp_cur.duty) else begin
            n_fail++;
            $error("FAIL duty edge=%0d observed=%h expected=%h", cyc, obs_duty, exp_cur.duty);
        end
        n_checks++;
        assert (bus_if.upd_pulse === exp_cur.upd) else begin
            n_fail++;
            $error("FAIL upd_pulse edge=%0d observed=%b expected=%b", cyc, bus_if.upd_pulse, exp_cur.upd);
        end
    end

    initial begin
        int unsigned c;
        int unsigned r;

        // 1: reset for 2 edges with all switches on; outputs stay 0.
        rst = 1'b1;
        bus_if.sw_raw     = 16'hFFFF;
        bus_if.frame_tick = 1'b0;
        step(2);
        rst = 1'b0;
        bus_if.sw_raw = 16'h0000;
        step(4);

        // 2: transparent mode, group 0 on; change at edge c+1+DB+2.
        bus_if.frame_tick = 1'b1;
        bus_if.sw_raw     = 16'h000F;
        c = cyc;
        push(c + 11, 16'h000F, 3'd0, 3'd0, 3'd0, 3'd4, 1'b1);
        push(c + 12, 16'h000F, 3'd0, 3'd0, 3'd0, 3'd4, 1'b0);
        step(14);

        // 3: bit 5 glitch of DB-1 cycles must never be accepted.
        bus_if.sw_raw = 16'h002F;
        step(7);
        bus_if.sw_raw = 16'h000F;
        step(15);

        // 4: tick every 16 cycles, change settles mid-frame.
        bus_if.frame_tick = 1'b0;
        step(5);
        bus_if.frame_tick = 1'b1;
        step(1);
        bus_if.frame_tick = 1'b0;
        step(2);
        bus_if.sw_raw = 16'h310F;
        c = cyc;
        push(c + 14, 16'h310F, 3'd2, 3'd1, 3'd0, 3'd4, 1'b1);
        push(c + 15, 16'h310F, 3'd2, 3'd1, 3'd0, 3'd4, 1'b0);
        step(13);
        bus_if.frame_tick = 1'b1;
        step(1);
        bus_if.frame_tick = 1'b0;
        step(15);
        bus_if.frame_tick = 1'b1;   // no change on this tick
        step(1);
        bus_if.frame_tick = 1'b0;
        step(3);

        // 5: reset after 5 disagreeing edges; everything requalifies.
        bus_if.frame_tick = 1'b1;
        bus_if.sw_raw     = 16'h314F;
        step(7);
        rst = 1'b1;
        c = cyc;
        push(c + 1, 16'h0000, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        step(1);
        rst = 1'b0;
        r = cyc;
        push(r + 11, 16'h314F, 3'd2, 3'd1, 3'd1, 3'd4, 1'b1);
        push(r + 12, 16'h314F, 3'd2, 3'd1, 3'd1, 3'd4, 1'b0);
        step(14);

        // 6: tick on the stable-update edge latches the old value.
        bus_if.frame_tick = 1'b0;
        step(3);
        bus_if.sw_raw = 16'h314E;
        c = cyc;
        step(9);
        bus_if.frame_tick = 1'b1;   // tick at edge c+10
        step(1);
        bus_if.frame_tick = 1'b0;
        push(c + 26, 16'h314E, 3'd2, 3'd1, 3'd1, 3'd3, 1'b1);
        push(c + 27, 16'h314E, 3'd2, 3'd1, 3'd1, 3'd3, 1'b0);
        step(15);
        bus_if.frame_tick = 1'b1;   // tick at edge c+26
        step(1);
        bus_if.frame_tick = 1'b0;
        step(4);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
